pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 139, meaning bit width of the carried stage payload (inst, addresses, data, enables concatenated).
REQ-002 SHALL have parameter DEPTH, default 1, legal 1..4, meaning number of chained register stages.
REQ-003 SHALL have port clk_100M input 1, the 100 MHz clock; all state updates on its rising edge.
REQ-004 SHALL have port arst_n input 1, reset, asynchronous, active-low.
REQ-005 SHALL have port hold input 1, the pipeline stall: freeze all state.
REQ-006 SHALL have port flush input 1, which kills all in-flight entries.
REQ-007 SHALL have port in_valid input 1, meaning upstream entry present.
REQ-008 SHALL have port in_ready output 1, meaning this block accepts in_payload this cycle.
REQ-009 SHALL have port in_payload input PAYLOAD_W, the upstream entry.
REQ-010 SHALL have port out_valid output 1, meaning downstream entry present.
REQ-011 SHALL have port out_ready input 1, meaning downstream accepts the entry.
REQ-012 SHALL have port out_payload output PAYLOAD_W, the downstream entry.
REQ-013 SHALL have port occupancy output 3, giving the count of valid entries held (stages plus skid).
REQ-014 SHALL have port stall_cnt output 16, a saturating count of stalled cycles.

Function
REQ-015 Each stage i SHALL hold valid bit v[i] and payload p[i]; stage 0 is fed from input, stage DEPTH-1 feeds output.
REQ-016 Advance adv SHALL be asserted when hold=0, flush=0 and the output slot is free (see REQ-017/REQ-030).
REQ-017 Without skid, output slot free SHALL mean v[DEPTH-1]=0 or out_ready=1.
REQ-018 On adv, v[0]<=in_valid, p[0]<=in_payload, and v[i]<=v[i-1], p[i]<=p[i-1] for i>=1; bubbles are carried, not compressed.
REQ-019 in_ready SHALL equal adv; an entry transfers in only when in_valid and in_ready are both 1.
REQ-020 Latency in to out SHALL be DEPTH cycles with no stalls.
REQ-021 out_valid SHALL equal (last valid entry present) AND hold=0; out_payload SHALL show that entry regardless of hold.
REQ-022 During hold=1 with flush=0, every v, p, skid bit and occupancy SHALL keep its value; no entry enters or leaves.
REQ-023 Flush SHALL take priority over hold and adv: next edge clears all v bits and skid valid, zeroes all payload registers, and forces in_ready=0 that cycle.
REQ-024 occupancy SHALL be updated registered, equal to the popcount of v[] plus skid valid.
REQ-025 stall_cnt SHALL increment by 1 each cycle where hold=1, or where out_valid=1 and out_ready=0; it SHALL saturate at 16'hFFFF and never wrap.
REQ-026 stall_cnt SHALL be unaffected by flush.
REQ-027 A single cycle with in-transfer and out-transfer simultaneously SHALL leave occupancy unchanged when DEPTH=1.

Reset
REQ-028 On arst_n=0, all v bits and skid valid SHALL be 0, all payload and skid registers SHALL be all-zero, occupancy 0, and stall_cnt 0, immediately and independent of clock.
REQ-029 Reset asserted mid-transfer SHALL discard all entries; the first edge after release SHALL behave as an empty block, with in_ready=1 if hold=0 and flush=0.

Configuration
REQ-030 Macro PIPE_SKID_EN defined: SHALL add one skid register after stage DEPTH-1; output slot free means skid empty, so in_ready SHALL NOT depend combinationally on out_ready.
REQ-031 With PIPE_SKID_EN, on adv with v[DEPTH-1]=1 and out_ready=0, the skid SHALL capture p[DEPTH-1]; while the skid is full, output SHALL be taken from the skid and adv=0; the skid SHALL empty when out_ready=1 and hold=0.
REQ-032 Macro PIPE_SKID_EN undefined: SHALL have no skid register; REQ-017 applies; occupancy maximum is DEPTH.

Verification
REQ-033 Stream: DEPTH=2, out_ready=1, payloads 0x01..0x05 on consecutive cycles -> 0x01..0x05 exit in order, each 2 cycles after entry, with no gaps.
REQ-034 Hold: assert hold 3 cycles with occupancy=2 -> out_valid=0, state frozen, stall_cnt +3, same payload order after release.
REQ-035 Flush during hold: occupancy=2, hold=1 and flush=1 together -> next cycle occupancy=0, out_payload=0, in_ready=0 during the flush cycle.
REQ-036 Backpressure: out_ready=0 for 4 cycles with input streaming -> no entry lost or duplicated; with PIPE_SKID_EN, occupancy peaks at DEPTH+1 and in_ready is independent of the same-cycle out_ready.
REQ-037 Saturation: force 70000 stalled cycles -> stall_cnt holds at 0xFFFF.
REQ-038 Reset mid-stream: drop arst_n with occupancy=2 -> all outputs 0 immediately; after release, 0xAA enters and appears after DEPTH cycles.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: DEPTH-deep valid/payload register chain with an optional
// skid register at the tail, a pipeline stall (hold) and a kill (flush).
// Optional feature macro: PIPE_SKID_EN adds one skid register after the
// last stage, so in_ready is no longer combinationally tied to out_ready.
// Bubbles travel with the chain; the stages do not compress them.
module pipe_stage_buf #(
    parameter int PAYLOAD_W = 139,
    parameter int DEPTH     = 1
) (
    input  logic                 clk_100M,
    input  logic                 arst_n,
    input  logic                 hold,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [2:0]           occupancy,
    output logic [15:0]          stall_cnt
);

    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
        $error("pipe_stage_buf: DEPTH must be in 1..4");
    end

    // Stage state: v_q[0]/p_q[0] is fed from the input, index DEPTH-1 drives the output.
    logic [DEPTH-1:0]     v_q, v_d;
    logic [PAYLOAD_W-1:0] p_q [DEPTH];
    logic [PAYLOAD_W-1:0] p_d [DEPTH];
    logic [2:0]           occ_q, occ_d;
    logic [15:0]          stall_q, stall_d;

    logic adv;
    logic slot_free;
    logic stall_evt;
    logic skid_nxt;

    // Number of valid entries held in the stages plus the skid slot.
    function automatic logic [2:0] count_valid(input logic [DEPTH-1:0] v, input logic extra);
        logic [2:0] n;
        n = {2'b00, extra};
        for (int i = 0; i < DEPTH; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

`ifdef PIPE_SKID_EN
    logic                 skid_v_q, skid_v_d;
    logic [PAYLOAD_W-1:0] skid_p_q, skid_p_d;

    // With the skid, the tail may advance whenever the skid is empty; a blocked
    // tail entry is parked in the skid instead of stalling the chain.
    always_comb begin
        slot_free   = ~skid_v_q;
        out_valid   = (skid_v_q | v_q[DEPTH-1]) & ~hold;
        out_payload = skid_v_q ? skid_p_q : p_q[DEPTH-1];
    end
`else
    // Without the skid, the tail may advance when it is empty or being taken.
    always_comb begin
        slot_free   = ~v_q[DEPTH-1] | out_ready;
        out_valid   = v_q[DEPTH-1] & ~hold;
        out_payload = p_q[DEPTH-1];
    end
`endif

    assign adv       = ~hold & ~flush & slot_free;
    assign in_ready  = adv;
    assign stall_evt = hold | (out_valid & ~out_ready);
    assign occupancy = occ_q;
    assign stall_cnt = stall_q;

    // Next state for stages and skid: flush clears, adv shifts, otherwise hold.
    always_comb begin
        v_d = v_q;
        p_d = p_q;
`ifdef PIPE_SKID_EN
        skid_v_d = skid_v_q;
        skid_p_d = skid_p_q;
`endif
        if (flush) begin
            v_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                p_d[i] = '0;
            end
`ifdef PIPE_SKID_EN
            skid_v_d = 1'b0;
            skid_p_d = '0;
`endif
        end else if (adv) begin
            v_d[0] = in_valid;
            p_d[0] = in_payload;
            for (int i = 1; i < DEPTH; i++) begin
                v_d[i] = v_q[i-1];
                p_d[i] = p_q[i-1];
            end
`ifdef PIPE_SKID_EN
            if (v_q[DEPTH-1] && !out_ready) begin
                skid_v_d = 1'b1;
                skid_p_d = p_q[DEPTH-1];
            end
`endif
        end else begin
`ifdef PIPE_SKID_EN
            if (skid_v_q && out_ready && !hold) begin
                skid_v_d = 1'b0;
            end
`endif
        end
    end

`ifdef PIPE_SKID_EN
    assign skid_nxt = skid_v_d;
`else
    assign skid_nxt = 1'b0;
`endif

    // Occupancy is registered from the next-state valid bits; stall count saturates.
    always_comb begin
        occ_d   = count_valid(v_d, skid_nxt);
        stall_d = stall_q;
        if (stall_evt && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Control registers: valid bits, occupancy and stall counter.
    always_ff @(posedge clk_100M or negedge arst_n) begin
        if (!arst_n) begin
            v_q     <= '0;
            occ_q   <= '0;
            stall_q <= '0;
        end else begin
            v_q     <= v_d;
            occ_q   <= occ_d;
            stall_q <= stall_d;
        end
    end

    // Payload registers are cleared on reset so nothing stale is ever visible.
    always_ff @(posedge clk_100M or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                p_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                p_q[i] <= p_d[i];
            end
        end
    end

`ifdef PIPE_SKID_EN
    // Skid register: holds the tail entry that could not leave when it advanced.
    always_ff @(posedge clk_100M or negedge arst_n) begin
        if (!arst_n) begin
            skid_v_q <= 1'b0;
            skid_p_q <= '0;
        end else begin
            skid_v_q <= skid_v_d;
            skid_p_q <= skid_p_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Testbench for pipe_stage_buf (DEPTH=2): directed scenarios plus random
// traffic, checked against a queue-based behavioural model and an in-order
// scoreboard of transferred payloads.
module tb_pipe_stage_buf;

    localparam int PW    = 139;
    localparam int DEPTH = 2;

    logic          clk_100M = 1'b0;
    logic          arst_n;
    logic          hold;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_payload;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_payload;
    logic [2:0]    occupancy;
    logic [15:0]   stall_cnt;

    always #5 clk_100M = ~clk_100M;

    pipe_stage_buf #(.PAYLOAD_W(PW), .DEPTH(DEPTH)) dut (
        .clk_100M   (clk_100M),
        .arst_n     (arst_n),
        .hold       (hold),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_payload (in_payload),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_payload(out_payload),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: pipe[0] is the newest slot, pipe[DEPTH-1] the oldest.
    typedef struct packed {
        logic          v;
        logic [PW-1:0] d;
    } slot_t;
    typedef struct {
        logic [PW-1:0] d;
        int            c;
    } sb_t;

    slot_t         pipe[$];
    logic          sk_v;
    logic [PW-1:0] sk_d;
    int            mstall;
    sb_t           sb[$];
    int            cyc;
    bit            lat_chk;
    int            peak_occ;
    int            s0;

    function automatic int model_occ();
        int n;
        n = int'(sk_v);
        foreach (pipe[i]) n += int'(pipe[i].v);
        return n;
    endfunction

    function automatic logic [PW-1:0] rand_pl();
        logic [159:0] r;
        for (int i = 0; i < 5; i++) r[32*i +: 32] = $urandom;
        return r[PW-1:0];
    endfunction

    task automatic model_clear();
        slot_t z;
        z = '0;
        pipe.delete();
        for (int i = 0; i < DEPTH; i++) pipe.push_back(z);
        sk_v = 1'b0;
        sk_d = '0;
        sb.delete();
    endtask

    task automatic drive(input logic h, input logic f, input logic iv,
                         input logic [PW-1:0] pl, input logic ordy);
        hold       = h;
        flush      = f;
        in_valid   = iv;
        in_payload = pl;
        out_ready  = ordy;
    endtask

    // One clock cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic step();
        slot_t         last;
        slot_t         nw;
        logic          e_free, e_adv, e_ov;
        logic [PW-1:0] e_op;
        sb_t           ent;
        @(negedge clk_100M);
        last = pipe[DEPTH-1];
`ifdef PIPE_SKID_EN
        e_free = !sk_v;
        e_ov   = (sk_v || last.v) && !hold;
        e_op   = sk_v ? sk_d : last.d;
`else
        e_free = !last.v || out_ready;
        e_ov   = last.v && !hold;
        e_op   = last.d;
`endif
        e_adv = !hold && !flush && e_free;
        chk("in_ready", 160'(in_ready), 160'(e_adv));
        chk("out_valid", 160'(out_valid), 160'(e_ov));
        chk("out_payload", 160'(out_payload), 160'(e_op));
        chk("occupancy", 160'(occupancy), 160'(model_occ()));
        chk("stall_cnt", 160'(stall_cnt), 160'(mstall));
        if (int'(occupancy) > peak_occ) peak_occ = int'(occupancy);
        if (e_ov && out_ready && !flush) begin
            chk("sb_nonempty", 160'(sb.size() > 0), 160'(1));
            if (sb.size() > 0) begin
                ent = sb.pop_front();
                chk("order", 160'(out_payload), 160'(ent.d));
                if (lat_chk) chk("latency", 160'(cyc - ent.c), 160'(DEPTH));
            end
        end
        @(posedge clk_100M);
        if (hold || (e_ov && !out_ready)) mstall = (mstall < 65535) ? mstall + 1 : 65535;
        if (flush) begin
            model_clear();
        end else if (e_adv) begin
            if (in_valid) begin
                ent.d = in_payload;
                ent.c = cyc;
                sb.push_back(ent);
            end
`ifdef PIPE_SKID_EN
            if (last.v && !out_ready) begin
                sk_v = 1'b1;
                sk_d = last.d;
            end
`endif
            nw.v = in_valid;
            nw.d = in_payload;
            void'(pipe.pop_back());
            pipe.push_front(nw);
        end else begin
`ifdef PIPE_SKID_EN
            if (sk_v && out_ready && !hold) sk_v = 1'b0;
`endif
        end
        cyc++;
        #1;
    endtask

    initial begin
        cyc      = 0;
        lat_chk  = 1'b0;
        peak_occ = 0;
        mstall   = 0;
        model_clear();
        drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
        arst_n = 1'b1;
        #2 arst_n = 1'b0;
        #1;
        chk("rst_out_valid", 160'(out_valid), 160'(0));
        chk("rst_out_payload", 160'(out_payload), 160'(0));
        chk("rst_occupancy", 160'(occupancy), 160'(0));
        chk("rst_stall_cnt", 160'(stall_cnt), 160'(0));
        @(posedge clk_100M);
        #1 arst_n = 1'b1;

        // Stream 0x01..0x05 back to back, each must exit DEPTH cycles later with no gaps.
        lat_chk = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            drive(1'b0, 1'b0, 1'b1, PW'(k), 1'b1);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, rand_pl(), 1'b1);
            step();
        end
        chk("stream_drained", 160'(sb.size()), 160'(0));
        lat_chk = 1'b0;

        // Hold three cycles with two entries in flight.
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 1'b1, rand_pl(), 1'b1);
            step();
        end
        chk("hold_pre_occ", 160'(occupancy), 160'(2));
        s0 = int'(stall_cnt);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b1, rand_pl(), 1'b1);
            step();
        end
        chk("hold_stall_delta", 160'(int'(stall_cnt) - s0), 160'(3));
        chk("hold_occ_kept", 160'(occupancy), 160'(2));
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'b0, rand_pl(), 1'b1);
            step();
        end

        // Flush while holding with two entries in flight.
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 1'b1, rand_pl(), 1'b0);
            step();
        end
        drive(1'b1, 1'b1, 1'b1, rand_pl(), 1'b1);
        step();
        chk("flush_occ", 160'(occupancy), 160'(0));
        chk("flush_payload", 160'(out_payload), 160'(0));
        drive(1'b0, 1'b0, 1'b0, rand_pl(), 1'b1);
        step();

        // Backpressure: four blocked cycles under a continuous input stream.
        peak_occ = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b1, rand_pl(), 1'b0);
            step();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 1'b0, 1'b1, rand_pl(), 1'b1);
            step();
        end
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 1'b0, rand_pl(), 1'b1);
            step();
        end
`ifdef PIPE_SKID_EN
        chk("bp_peak_occ", 160'(peak_occ), 160'(DEPTH + 1));
`else
        chk("bp_peak_occ", 160'(peak_occ), 160'(DEPTH));
`endif
        chk("bp_drained", 160'(sb.size()), 160'(0));

        // Random traffic.
        for (int k = 0; k < 1500; k++) begin
            drive(($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 3),
                  ($urandom_range(0, 99) < 70), rand_pl(), ($urandom_range(0, 99) < 70));
            step();
        end
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 1'b0, rand_pl(), 1'b1);
            step();
        end
        chk("rand_drained", 160'(sb.size()), 160'(0));

        // Saturation: 70000 held cycles.
        drive(1'b1, 1'b0, 1'b0, rand_pl(), 1'b1);
        repeat (70000) @(posedge clk_100M);
        #1;
        mstall = (mstall + 70000 > 65535) ? 65535 : mstall + 70000;
        chk("stall_sat", 160'(stall_cnt), 160'(16'hFFFF));
        step();
        chk("stall_nowrap", 160'(stall_cnt), 160'(16'hFFFF));

        // Reset with two entries in flight, then 0xAA passes through an empty block.
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 1'b1, rand_pl(), 1'b0);
            step();
        end
        chk("mid_pre_occ", 160'(occupancy), 160'(2));
        #1 arst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 160'(out_valid), 160'(0));
        chk("mid_rst_out_payload", 160'(out_payload), 160'(0));
        chk("mid_rst_occupancy", 160'(occupancy), 160'(0));
        chk("mid_rst_stall_cnt", 160'(stall_cnt), 160'(0));
        model_clear();
        mstall = 0;
        #1 arst_n = 1'b1;
        lat_chk = 1'b1;
        drive(1'b0, 1'b0, 1'b1, PW'(8'hAA), 1'b1);
        step();
        for (int k = 0; k < DEPTH + 2; k++) begin
            drive(1'b0, 1'b0, 1'b0, '0, 1'b1);
            step();
        end
        chk("aa_drained", 160'(sb.size()), 160'(0));
        lat_chk = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
